// File: rtl/occ_pkg.sv
// Shared types and default sizing for the lot occupancy tracker.
package occ_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      EN1  = 3'd1,
      EN2  = 3'd2,
      EN3  = 3'd3,
      EX1  = 3'd4,
      EX2  = 3'd5,
      EX3  = 3'd6
   } occ_state_t;

   localparam int CAPACITY_DEF = 25;
   localparam int CNT_W_DEF    = 5;

endpackage

// File: rtl/sensor_sync.sv
// Two-flop synchronizer with synchronous active-high reset; used on the gate
// sensor pins when OCC_INPUT_SYNC_EN is defined.
module sensor_sync #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_r;
   logic [WIDTH-1:0] sync_r;

   // two-stage capture of the asynchronous input
   always_ff @(posedge clk) begin
      if (reset) begin
         meta_r <= {WIDTH{1'b0}};
         sync_r <= {WIDTH{1'b0}};
      end else begin
         meta_r <= d;
         sync_r <= meta_r;
      end
   end

   assign q = sync_r;

endmodule

// File: rtl/lot_occupancy_tracker.sv
// Gate sensor decoder and saturating occupancy counter for the lot display.
// Optional input synchronizers are enabled with the OCC_INPUT_SYNC_EN macro.
module lot_occupancy_tracker
   import occ_pkg::*;
#(
   parameter int CAPACITY = CAPACITY_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sensor_a,
   input  logic             sensor_b,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             clear,
   output logic             enter,
   output logic             exit
);

   localparam logic [CNT_W-1:0] CAP_V = CNT_W'(CAPACITY);

   logic             a_s;
   logic             b_s;
   logic [1:0]       ab_s;
   occ_state_t       state_r;
   occ_state_t       state_nxt_s;
   logic             enter_evt_s;
   logic             exit_evt_s;
   logic [CNT_W-1:0] count_r;
   logic [CNT_W-1:0] count_nxt_s;
   logic             full_r;
   logic             clear_r;
   logic             enter_r;
   logic             exit_r;

`ifdef OCC_INPUT_SYNC_EN
   sensor_sync #(.WIDTH(1)) u_sync_a (
      .clk   (clk),
      .reset (reset),
      .d     (sensor_a),
      .q     (a_s)
   );

   sensor_sync #(.WIDTH(1)) u_sync_b (
      .clk   (clk),
      .reset (reset),
      .d     (sensor_b),
      .q     (b_s)
   );
`else
   assign a_s = sensor_a;
   assign b_s = sensor_b;
`endif

   assign ab_s = {a_s, b_s};

   // passage decoder: events fire only on the final all-clear sample
   always_comb begin
      state_nxt_s = state_r;
      enter_evt_s = 1'b0;
      exit_evt_s  = 1'b0;
      case (state_r)
         IDLE: begin
            case (ab_s)
               2'b10:   state_nxt_s = EN1;
               2'b01:   state_nxt_s = EX1;
               default: state_nxt_s = IDLE;
            endcase
         end
         EN1: begin
            case (ab_s)
               2'b10:   state_nxt_s = EN1;
               2'b11:   state_nxt_s = EN2;
               default: state_nxt_s = IDLE;
            endcase
         end
         EN2: begin
            case (ab_s)
               2'b11:   state_nxt_s = EN2;
               2'b01:   state_nxt_s = EN3;
               2'b10:   state_nxt_s = EN1;
               default: state_nxt_s = IDLE;
            endcase
         end
         EN3: begin
            case (ab_s)
               2'b01:   state_nxt_s = EN3;
               2'b11:   state_nxt_s = EN2;
               2'b00: begin
                  state_nxt_s = IDLE;
                  enter_evt_s = 1'b1;
               end
               default: state_nxt_s = IDLE;
            endcase
         end
         EX1: begin
            case (ab_s)
               2'b01:   state_nxt_s = EX1;
               2'b11:   state_nxt_s = EX2;
               default: state_nxt_s = IDLE;
            endcase
         end
         EX2: begin
            case (ab_s)
               2'b11:   state_nxt_s = EX2;
               2'b10:   state_nxt_s = EX3;
               2'b01:   state_nxt_s = EX1;
               default: state_nxt_s = IDLE;
            endcase
         end
         EX3: begin
            case (ab_s)
               2'b10:   state_nxt_s = EX3;
               2'b11:   state_nxt_s = EX2;
               2'b00: begin
                  state_nxt_s = IDLE;
                  exit_evt_s  = 1'b1;
               end
               default: state_nxt_s = IDLE;
            endcase
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // saturating count: pulses still fire when the count cannot move
   always_comb begin
      count_nxt_s = count_r;
      if (enter_evt_s) begin
         if (count_r < CAP_V) begin
            count_nxt_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            count_nxt_s = count_r;
         end
      end else if (exit_evt_s) begin
         if (count_r != {CNT_W{1'b0}}) begin
            count_nxt_s = count_r - {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            count_nxt_s = count_r;
         end
      end else begin
         count_nxt_s = count_r;
      end
   end

   // state, count and flag registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
         count_r <= {CNT_W{1'b0}};
         full_r  <= 1'b0;
         clear_r <= 1'b1;
         enter_r <= 1'b0;
         exit_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         count_r <= count_nxt_s;
         full_r  <= (count_nxt_s == CAP_V);
         clear_r <= (count_nxt_s == {CNT_W{1'b0}});
         enter_r <= enter_evt_s;
         exit_r  <= exit_evt_s;
      end
   end

   assign count = count_r;
   assign full  = full_r;
   assign clear = clear_r;
   assign enter = enter_r;
   assign exit  = exit_r;

endmodule
